rv32imf_clint: RTL
==================

Name: rv32imf_clint

Overview:
- Core-local interrupt/timer block; sits directly upstream of the rv32imf top.
- Produces the 64-bit time_i value and the machine timer/software interrupt lines on irq_i.
- Memory-mapped OBI slave, reached from the core data port through the system interconnect.
- Holds mtime, mtimecmp and msip, RISC-V privileged-spec style.

Parameters:
- BASE_ADDR, 32'h0200_0000, byte base address of the 32-byte register window.
- PRESCALE, 1, clk_i cycles per mtime increment; legal 1..65535; used only when RV32IMF_CLINT_PRESCALER_EN is defined.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous and active-low.
- req_i  in  1  OBI request.
- gnt_o  out  1  OBI grant.
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- time_o  out  64  mtime value; drives time_i.
- irq_o  out  32  interrupt vector; drives irq_i.

Behaviour:
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0.
  - rvalid_o = 0, rdata_o = 0, irq_o = 0, time_o = 0.
- Handshake:
  - gnt_o = req_i, combinational; one transfer is accepted per cycle, back-to-back allowed.
  - Accept = req_i & gnt_o.
  - rvalid_o is asserted exactly one cycle after each accept, for one cycle, for reads and writes alike.
  - rdata_o is valid only while rvalid_o = 1. It is 0 on write responses and holds its last value otherwise.
- Address decode:
  - Hit when addr_i[31:5] == BASE_ADDR[31:5]. Offset = addr_i[4:2]; addr_i[1:0] is ignored.
  - Offset 0 (0x00): msip, bit 0 only; bits 31:1 read 0.
  - Offset 2 (0x08): mtimecmp[31:0].
  - Offset 3 (0x0C): mtimecmp[63:32].
  - Offset 4 (0x10): mtime[31:0].
  - Offset 5 (0x14): mtime[63:32].
  - Other offsets and non-hit addresses: reads return 0, writes are ignored, and the transfer is still granted and responded to.
- Writes:
  - Byte-granular per be_i.
  - Registers update on the clock edge that ends the accept cycle.
  - be_i = 0 is a legal no-op write.
- Reads:
  - Register value sampled at the accept cycle, i.e. the pre-update value.
  - A read of mtime returns the value before that cycle's increment.
- Counter:
  - tick = 1 every cycle; with the optional feature, tick comes from the prescaler.
  - On tick, mtime <= mtime + 1 (64-bit). Wrap from all-ones to 0 is silent.
  - In a cycle where either mtime word is written, the write takes priority and that cycle's increment is dropped for the whole 64-bit value.
- Interrupts:
  - mtip register <= (mtime >= mtimecmp), unsigned 64-bit compare of current register values, evaluated every cycle.
  - irq_o[7] = mtip, irq_o[3] = msip; all other bits are 0.
  - Writing mtimecmp above mtime clears irq_o[7] within 2 cycles of the accept.
- time_o = mtime, the register output, with no extra delay.
- Reset asserted mid-transfer clears everything asynchronously. No response is issued for a transfer accepted in the cycle reset asserts.

Optional Feature:
- Macro: RV32IMF_CLINT_PRESCALER_EN.
- Defined:
  - A 16-bit prescale counter counts 0..PRESCALE-1.
  - tick = 1 when the counter equals PRESCALE-1, and the counter then wraps to 0.
  - Counter resets to 0; it is not cleared by mtime writes.
  - PRESCALE = 1 gives a tick every cycle.
- Undefined: there is no prescale counter, tick = 1 every cycle, and PRESCALE is ignored.

Decomposition:
- rv32imf_pkg gains:
  - CLINT offset constants: CLINT_MSIP_OFS, CLINT_MTIMECMP_LO_OFS, CLINT_MTIMECMP_HI_OFS, CLINT_MTIME_LO_OFS, CLINT_MTIME_HI_OFS.
  - IRQ bit indices IRQ_MSI = 3 and IRQ_MTI = 7.
- One sub-module, rv32imf_clint_timer: holds mtime, the optional prescaler, the write-override path and the compare/mtip register.
- The top handles OBI decode, msip, mtimecmp and the response register.

Test Plan:
- Reset release, no bus traffic, run 100 cycles -> time_o = 100, irq_o = 0, rvalid_o never asserted.
- Write 0x08 = 0x20, then 0x0C = 0, at time < 0x20 -> irq_o[7] rises once mtime >= 0x20 (on the cycle after mtime reaches 0x20). Then write 0x0C = 1 -> irq_o[7] falls within 2 cycles.
- Write 0x00 = 0xFFFF_FFFF, then read 0x00 -> irq_o = 32'h8; read returns 0x1 one cycle after accept. Write 0x00 = 0 -> irq_o[3] = 0.
- Write 0x10 = 0xFFFF_FFFF and 0x14 = 0xFFFF_FFFF (be 4'hF) -> mtime = all-ones, wraps to 0 on the next tick, no error.
- Back-to-back reads of 0x10 for 3 cycles -> rvalid_o high 3 consecutive cycles, values N, N+1, N+2. Write 0x10 with be_i = 4'b0010, wdata = 0x0000_AB00 -> only byte 1 changes.
- With RV32IMF_CLINT_PRESCALER_EN and PRESCALE = 4, run 40 cycles -> time_o = 10. Read at 0x18 or outside BASE_ADDR -> rdata_o = 0, rvalid_o still asserted.

Source files
------------

// File: rtl/rv32imf_pkg.sv
// Shared rv32imf definitions: CLINT register offsets, IRQ bit indices and bus payload types.
package rv32imf_pkg;

  localparam int unsigned CLINT_AW  = 32;
  localparam int unsigned CLINT_DW  = 32;
  localparam int unsigned CLINT_BEW = CLINT_DW / 8;
  localparam int unsigned CLINT_OFW = 3;

  // Word offsets (addr[4:2]) inside the 32-byte CLINT window
  localparam logic [CLINT_OFW-1:0] CLINT_MSIP_OFS        = 3'd0;
  localparam logic [CLINT_OFW-1:0] CLINT_MTIMECMP_LO_OFS = 3'd2;
  localparam logic [CLINT_OFW-1:0] CLINT_MTIMECMP_HI_OFS = 3'd3;
  localparam logic [CLINT_OFW-1:0] CLINT_MTIME_LO_OFS    = 3'd4;
  localparam logic [CLINT_OFW-1:0] CLINT_MTIME_HI_OFS    = 3'd5;

  localparam int unsigned IRQ_MSI = 3;
  localparam int unsigned IRQ_MTI = 7;

  typedef struct packed {
    logic                 we;
    logic [CLINT_BEW-1:0] be;
    logic [CLINT_AW-1:0]  addr;
    logic [CLINT_DW-1:0]  wdata;
  } clint_req_t;

  function automatic logic [CLINT_DW-1:0] be_merge(input logic [CLINT_DW-1:0]  old_val,
                                                   input logic [CLINT_DW-1:0]  wdata,
                                                   input logic [CLINT_BEW-1:0] be);
    logic [CLINT_DW-1:0] res;
    res = old_val;
    for (int i = 0; i < int'(CLINT_BEW); i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rv32imf_clint_if.sv
// OBI slave port bundle for the CLINT.
interface rv32imf_clint_if;
  import rv32imf_pkg::*;

  logic                 req;
  logic                 gnt;
  logic                 we;
  logic [CLINT_BEW-1:0] be;
  logic [CLINT_AW-1:0]  addr;
  logic [CLINT_DW-1:0]  wdata;
  logic                 rvalid;
  logic [CLINT_DW-1:0]  rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/rv32imf_clint_timer.sv
// mtime counter with write override, optional prescaler and registered mtime >= mtimecmp compare.
// Optional feature: RV32IMF_CLINT_PRESCALER_EN enables the PRESCALE tick divider.
module rv32imf_clint_timer
  import rv32imf_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [CLINT_DW-1:0]  wdata,
  input  logic [CLINT_BEW-1:0] be,
  input  logic [63:0]          mtimecmp,
  output logic [63:0]          mtime,
  output logic                 mtip
);

  logic        tick_c;
  logic [63:0] mtime_nxt_c;

`ifdef RV32IMF_CLINT_PRESCALER_EN
  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);
  logic [15:0] ps_cnt;

  // Free-running divider; mtime writes do not disturb it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                ps_cnt <= '0;
    else if (ps_cnt == PS_LAST) ps_cnt <= '0;
    else                        ps_cnt <= ps_cnt + 16'd1;
  end

  assign tick_c = (ps_cnt == PS_LAST);
`else
  localparam int unsigned UNUSED_PRESCALE = PRESCALE;
  assign tick_c = 1'b1;
`endif

  // A write to either word suppresses the increment for the full 64 bits
  always_comb begin
    mtime_nxt_c = mtime;
    if (wr_lo) mtime_nxt_c[31:0]  = be_merge(mtime[31:0], wdata, be);
    if (wr_hi) mtime_nxt_c[63:32] = be_merge(mtime[63:32], wdata, be);
    if (!wr_lo && !wr_hi && tick_c) mtime_nxt_c = mtime + 64'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime <= '0;
      mtip  <= 1'b0;
    end else begin
      mtime <= mtime_nxt_c;
      mtip  <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/rv32imf_clint.sv
// Core-local interruptor: OBI-mapped msip/mtimecmp/mtime, drives time and machine timer/software IRQs.
// Optional feature: RV32IMF_CLINT_PRESCALER_EN (mtime advances every PRESCALE cycles).
module rv32imf_clint
  import rv32imf_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  rv32imf_clint_if.slave  bus,
  output logic [63:0]     time_o,
  output logic [31:0]     irq_o
);

  clint_req_t            rq;
  logic                  acc_c;
  logic                  hit_c;
  logic                  wr_c;
  logic [CLINT_OFW-1:0]  ofs_c;
  logic [CLINT_DW-1:0]   rd_c;
  logic [1:0]            unused_addr_lo;
  logic                  msip;
  logic [63:0]           mtimecmp;
  logic                  mtip;

  assign rq = '{we: bus.we, be: bus.be, addr: bus.addr, wdata: bus.wdata};

  assign bus.gnt        = bus.req;
  assign acc_c          = bus.req & bus.gnt;
  assign hit_c          = (rq.addr[31:5] == BASE_ADDR[31:5]);
  assign ofs_c          = rq.addr[4:2];
  assign wr_c           = acc_c & rq.we & hit_c;
  assign unused_addr_lo = rq.addr[1:0];

  // Read mux over current (pre-update) register values
  always_comb begin
    rd_c = '0;
    if (hit_c) begin
      case (ofs_c)
        CLINT_MSIP_OFS:        rd_c = {31'd0, msip};
        CLINT_MTIMECMP_LO_OFS: rd_c = mtimecmp[31:0];
        CLINT_MTIMECMP_HI_OFS: rd_c = mtimecmp[63:32];
        CLINT_MTIME_LO_OFS:    rd_c = time_o[31:0];
        CLINT_MTIME_HI_OFS:    rd_c = time_o[63:32];
        default:               rd_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      msip       <= 1'b0;
      mtimecmp   <= '1;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
    end else begin
      bus.rvalid <= acc_c;
      if (acc_c) bus.rdata <= rq.we ? '0 : rd_c;
      if (wr_c && ofs_c == CLINT_MSIP_OFS && rq.be[0]) msip <= rq.wdata[0];
      if (wr_c && ofs_c == CLINT_MTIMECMP_LO_OFS)
        mtimecmp[31:0] <= be_merge(mtimecmp[31:0], rq.wdata, rq.be);
      if (wr_c && ofs_c == CLINT_MTIMECMP_HI_OFS)
        mtimecmp[63:32] <= be_merge(mtimecmp[63:32], rq.wdata, rq.be);
    end
  end

  rv32imf_clint_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wr_lo    (wr_c && ofs_c == CLINT_MTIME_LO_OFS),
    .wr_hi    (wr_c && ofs_c == CLINT_MTIME_HI_OFS),
    .wdata    (rq.wdata),
    .be       (rq.be),
    .mtimecmp (mtimecmp),
    .mtime    (time_o),
    .mtip     (mtip)
  );

  always_comb begin
    irq_o          = '0;
    irq_o[IRQ_MTI] = mtip;
    irq_o[IRQ_MSI] = msip;
  end

endmodule
